// File: rtl/load_pkg.sv
// Shared definitions for the memory-stage load unit: op codes, FSM states
// and the default data-side memory map.
package load_pkg;

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LB  = 3'd4;
    localparam logic [2:0] LD_LBU = 3'd5;
    localparam logic [2:0] LD_LWU = 3'd6;
    localparam logic [2:0] LD_LD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam logic [31:0] DM_TOP_DEF   = 32'h0000_2fff;
    localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7f00;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7f10;
    localparam logic [31:0] IRQ_BASE_DEF = 32'h0000_7f20;
    localparam logic [31:0] TC_SPAN      = 32'd12;
    localparam logic [31:0] IRQ_SPAN     = 32'd4;

    function automatic logic is_sub_word(input logic [2:0] op);
        return (op == LD_LH) || (op == LD_LHU) || (op == LD_LB) || (op == LD_LBU);
    endfunction

endpackage

// File: rtl/load_ext.sv
// Lane select and sign/zero extension of a returned bus word.
module load_ext
    import load_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                   op_i,
    input  logic [$clog2(DATA_W/8)-1:0]  off_i,
    input  logic [DATA_W-1:0]            word_i,
    output logic [DATA_W-1:0]            data_o
);

    logic [DATA_W-1:0] shifted;

    // Bring the addressed lane down to bit 0; little-endian byte order.
    assign shifted = word_i >> {off_i, 3'b000};

    always_comb begin
        data_o = '0;
        case (op_i)
            LD_LW:   data_o = DATA_W'(signed'(shifted[31:0]));
            LD_LWU:  data_o = DATA_W'(shifted[31:0]);
            LD_LH:   data_o = DATA_W'(signed'(shifted[15:0]));
            LD_LHU:  data_o = DATA_W'(shifted[15:0]);
            LD_LB:   data_o = DATA_W'(signed'(shifted[7:0]));
            LD_LBU:  data_o = DATA_W'(shifted[7:0]);
            LD_LD:   data_o = shifted;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/m_load_unit.sv
// Handshaked load unit: address checks, word-aligned bus read, lane extract.
// Optional bus-wait timeout enabled by defining LOAD_TIMEOUT_EN.
module m_load_unit
    import load_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] DM_TOP   = DM_TOP_DEF,
    parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
    parameter logic [31:0] IRQ_BASE = IRQ_BASE_DEF,
    parameter int          TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ov,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_exc,
    output logic              rsp_tmo
);

    localparam int OFF_W = $clog2(DATA_W/8);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_exc_q, rsp_exc_d;
    logic [DATA_W-1:0] ext_data;

    logic op_legal, misaligned, in_ram, in_tc, in_irq, req_exc;

    always_comb begin
        op_legal   = 1'b1;
        misaligned = 1'b0;
        case (req_op)
            LD_LW, LD_LWU: misaligned = |req_addr[1:0];
            LD_LH, LD_LHU: misaligned = req_addr[0];
            LD_LB, LD_LBU: misaligned = 1'b0;
            LD_LD: begin
                op_legal   = (DATA_W == 64);
                misaligned = |req_addr[2:0];
            end
            default: op_legal = 1'b0;
        endcase
    end

    assign in_ram = req_addr <= ADDR_W'(DM_TOP);
    assign in_tc  = ((req_addr >= ADDR_W'(TC0_BASE)) && (req_addr < ADDR_W'(TC0_BASE + TC_SPAN)))
                 || ((req_addr >= ADDR_W'(TC1_BASE)) && (req_addr < ADDR_W'(TC1_BASE + TC_SPAN)));
    assign in_irq = (req_addr >= ADDR_W'(IRQ_BASE)) && (req_addr < ADDR_W'(IRQ_BASE + IRQ_SPAN));

    // Timer registers only tolerate full-word reads.
    assign req_exc = req_ov || !op_legal || misaligned
                  || (is_sub_word(req_op) && in_tc)
                  || !(in_ram || in_tc || in_irq);

    load_ext #(.DATA_W(DATA_W)) u_ext (
        .op_i   (op_q),
        .off_i  (off_q),
        .word_i (bus_rdata),
        .data_o (ext_data)
    );

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_tmo_q, rsp_tmo_d;
    assign rsp_tmo = rsp_tmo_q;
`else
    assign rsp_tmo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        off_d      = off_q;
        bus_addr_d = bus_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_exc_d  = rsp_exc_q;
`ifdef LOAD_TIMEOUT_EN
        cnt_d      = cnt_q;
        rsp_tmo_d  = rsp_tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    off_d      = req_addr[OFF_W-1:0];
                    rsp_data_d = '0;
                    rsp_exc_d  = req_exc;
`ifdef LOAD_TIMEOUT_EN
                    cnt_d      = '0;
                    rsp_tmo_d  = 1'b0;
`endif
                    if (req_exc) begin
                        state_d = ST_RSP;
                    end else begin
                        bus_addr_d = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        state_d    = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    rsp_data_d = ext_data;
                    state_d    = ST_RSP;
                end
`ifdef LOAD_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rsp_exc_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    state_d   = ST_RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            off_q      <= '0;
            bus_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_exc_q  <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            cnt_q      <= '0;
            rsp_tmo_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            bus_addr_q <= bus_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_exc_q  <= rsp_exc_d;
`ifdef LOAD_TIMEOUT_EN
            cnt_q      <= cnt_d;
            rsp_tmo_q  <= rsp_tmo_d;
`endif
        end
    end

    assign req_ready = reset && (state_q == ST_IDLE);
    assign bus_req   = (state_q == ST_BUS);
    assign rsp_valid = (state_q == ST_RSP);
    assign bus_addr  = bus_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_exc   = rsp_exc_q;

endmodule

// File: tb/tb_m_load_unit.sv
// Self-checking bench for m_load_unit: directed cases plus randomized loads
// against an arithmetic memory-map/extension model.
module tb_m_load_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_addr;
    logic          req_ov;
    logic          bus_req;
    logic [31:0]   bus_addr;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_exc;
    logic          rsp_tmo;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    m_load_unit #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_ov    (req_ov),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_exc   (rsp_exc),
        .rsp_tmo   (rsp_tmo)
    );

    always #5 clk = ~clk;

    // Reference: access size, memory map and extension derived with plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr, input logic ov,
                                  input logic [DW-1:0] rd, output logic exc, output logic [DW-1:0] data);
        int size;
        int off;
        bit sgn;
        bit legal;
        bit ram, tc, irq;
        logic [63:0] v;
        size = 0; sgn = 0; legal = 1;
        case (op)
            3'd1: begin size = 4; sgn = 1; end
            3'd2: begin size = 2; sgn = 1; end
            3'd3: size = 2;
            3'd4: begin size = 1; sgn = 1; end
            3'd5: size = 1;
            3'd6: size = 4;
            3'd7: begin size = 8; legal = (DW == 64); end
            default: legal = 0;
        endcase
        ram = (addr <= 32'h2fff);
        tc  = (addr >= 32'h7f00 && addr < 32'h7f0c) || (addr >= 32'h7f10 && addr < 32'h7f1c);
        irq = (addr >= 32'h7f20 && addr < 32'h7f24);
        exc = ov || !legal || !(ram || tc || irq);
        if (legal && size != 0) begin
            if ((addr % size) != 0) exc = 1;
            if (size < 4 && tc) exc = 1;
        end
        v = 64'h0;
        if (!exc) begin
            off = int'(addr % (DW/8));
            for (int i = 0; i < size; i++) v = v | (64'(rd[8*(off+i) +: 8]) << (8*i));
            if (sgn && size < 8 && v[8*size-1]) v = v | (~64'h0 << (8*size));
        end
        data = DW'(v);
    endfunction

    task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic ov,
                            input logic [DW-1:0] rd, input int waits, input int stall);
        logic          exp_exc;
        logic [DW-1:0] exp_data;
        logic [31:0]   exp_baddr;
        model(op, addr, ov, rd, exp_exc, exp_data);
        exp_baddr = addr - (addr % (DW/8));
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ready: req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_ov = ov;
        @(negedge clk);
        req_valid = 1'b0; req_ov = 1'b0;
        if (exp_exc) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || bus_req !== 1'b0) begin
                n_fail++; $display("FAIL exc_latency: rsp_valid=%b bus_req=%b want 1/0", rsp_valid, bus_req);
            end
        end else begin
            n_checks++;
            if (bus_req !== 1'b1 || bus_addr !== exp_baddr || rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL bus_issue: bus_req=%b bus_addr=%h rsp_valid=%b want 1/%h/0", bus_req, bus_addr, rsp_valid, exp_baddr);
            end
            for (int w = 0; w < waits; w++) begin
                @(negedge clk);
                n_checks++;
                if (bus_req !== 1'b1 || bus_addr !== exp_baddr || rsp_valid !== 1'b0) begin
                    n_fail++; $display("FAIL bus_wait: bus_req=%b bus_addr=%h rsp_valid=%b want 1/%h/0", bus_req, bus_addr, rsp_valid, exp_baddr);
                end
            end
            bus_ack = 1'b1; bus_rdata = rd;
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = DW'($urandom);
            n_checks++;
            if (rsp_valid !== 1'b1 || bus_req !== 1'b0) begin
                n_fail++; $display("FAIL rsp_latency: rsp_valid=%b bus_req=%b want 1/0", rsp_valid, bus_req);
            end
        end
        n_checks++;
        if (rsp_exc !== exp_exc || rsp_data !== exp_data || rsp_tmo !== 1'b0) begin
            n_fail++; $display("FAIL rsp_value: op=%0d addr=%h exc=%b data=%h tmo=%b want %b/%h/0", op, addr, rsp_exc, rsp_data, rsp_tmo, exp_exc, exp_data);
        end
        for (int s = 0; s < stall; s++) begin
            bus_ack = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_exc !== exp_exc || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL rsp_stall: valid=%b data=%h exc=%b ready=%b want 1/%h/%b/0", rsp_valid, rsp_data, rsp_exc, req_ready, exp_data, exp_exc);
            end
        end
        bus_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rsp_release: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
        n_txn++;
        $display("txn %0d op=%0d addr=%h ov=%b waits=%0d stall=%0d exc=%b data=%h", n_txn, op, addr, ov, waits, stall, exp_exc, exp_data);
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_ov = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || bus_req !== 1'b0 || bus_addr !== 32'h0 || rsp_valid !== 1'b0
            || rsp_data !== '0 || rsp_exc !== 1'b0 || rsp_tmo !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: ready=%b breq=%b baddr=%h valid=%b data=%h exc=%b tmo=%b want all 0",
                               req_ready, bus_req, bus_addr, rsp_valid, rsp_data, rsp_exc, rsp_tmo);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release: req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_directed();
        run_load(3'd4, 32'h0000_0013, 1'b0, 32'h80FF_7F01, 0, 0);  // lb
        run_load(3'd3, 32'h0000_0002, 1'b0, 32'h9ABC_1234, 3, 0);  // lhu, 3 waits
        run_load(3'd1, 32'h0000_0006, 1'b0, 32'h1111_2222, 0, 0);  // lw misaligned
        run_load(3'd2, 32'h0000_7f04, 1'b0, 32'h1111_2222, 0, 0);  // lh timer
        run_load(3'd1, 32'h0000_7f04, 1'b0, 32'h8765_4321, 1, 0);  // lw timer ok
        run_load(3'd1, 32'h0000_0100, 1'b1, 32'h1111_2222, 0, 0);  // overflow
        run_load(3'd0, 32'h0000_0100, 1'b0, 32'h1111_2222, 0, 0);  // illegal op
        run_load(3'd7, 32'h0000_0100, 1'b0, 32'h1111_2222, 0, 0);  // ld on 32-bit
        run_load(3'd5, 32'h0000_3000, 1'b0, 32'h1111_2222, 0, 0);  // past RAM
        run_load(3'd1, 32'h0000_2ffc, 1'b0, 32'hF00D_BEEF, 0, 0);  // last RAM word
        run_load(3'd4, 32'h0000_7f21, 1'b0, 32'h0000_9900, 2, 0);  // lb in IRQ window
        run_load(3'd1, 32'h0000_7f0c, 1'b0, 32'h1111_2222, 0, 0);  // just past TC0
        run_load(3'd2, 32'h0000_7f16, 1'b0, 32'h1111_2222, 0, 0);  // lh in TC1
        run_load(3'd6, 32'h0000_0040, 1'b0, 32'hCAFE_0001, 0, 0);  // lwu
    endtask

    task automatic test_stall();
        run_load(3'd2, 32'h0000_0022, 1'b0, 32'h8001_7FFF, 1, 5);
    endtask

    task automatic test_ack_outside_bus();
        bus_ack = 1'b1; bus_rdata = DW'($urandom);
        repeat (2) @(negedge clk);
        bus_ack = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ack: rsp_valid=%b bus_req=%b req_ready=%b want 0/0/1", rsp_valid, bus_req, req_ready);
        end
    endtask

    task automatic test_reset_in_bus();
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h0000_0100; req_ov = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (bus_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_bus_pre: bus_req=%b want 1", bus_req);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || bus_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_bus: bus_req=%b rsp_valid=%b req_ready=%b bus_addr=%h want 0/0/0/0", bus_req, rsp_valid, req_ready, bus_addr);
        end
        reset = 1'b1; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_late_ack: rsp_valid=%b bus_req=%b req_ready=%b want 0/0/1", rsp_valid, bus_req, req_ready);
        end
        run_load(3'd5, 32'h0000_0101, 1'b0, 32'h0000_C300, 0, 0);
    endtask

`ifdef LOAD_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h0000_0040; req_ov = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            n_checks++;
            if (bus_req !== 1'b1 || rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL tmo_wait: cycle %0d bus_req=%b rsp_valid=%b want 1/0", j, bus_req, rsp_valid);
            end
            @(negedge clk);
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_exc !== 1'b1 || rsp_tmo !== 1'b1 || rsp_data !== '0 || bus_req !== 1'b0) begin
            n_fail++; $display("FAIL tmo_rsp: valid=%b exc=%b tmo=%b data=%h breq=%b want 1/1/1/0/0", rsp_valid, rsp_exc, rsp_tmo, rsp_data, bus_req);
        end
        bus_ack = 1'b1; bus_rdata = DW'($urandom);
        @(negedge clk);
        bus_ack = 1'b0;
        n_checks++;
        if (rsp_tmo !== 1'b1 || rsp_data !== '0) begin
            n_fail++; $display("FAIL tmo_late_ack: tmo=%b data=%h want 1/0", rsp_tmo, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("txn timeout lw addr=00000040");
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  op;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0: a = 32'($urandom) & 32'h0000_2fff;
                1: a = 32'h7f00 + 32'($urandom_range(0, 15));
                2: a = 32'h7f10 + 32'($urandom_range(0, 15));
                3: a = 32'h7f20 + 32'($urandom_range(0, 7));
                4: a = 32'($urandom);
                default: a = 32'h2ff8 + 32'($urandom_range(0, 15));
            endcase
            // Bias toward aligned addresses so most loads reach the bus.
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            op = 3'($urandom_range(0, 7));
            run_load(op, a, 1'($urandom_range(0, 7) == 0), DW'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_ack_outside_bus();
        test_reset_in_bus();
`ifdef LOAD_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_load_unit.md
# m_load_unit

Memory-stage load unit that replaces the purely combinational byte/halfword extractor with a handshaked, parametrised block. It accepts one load request per transaction, checks the address against the architectural alignment and memory-map rules, and issues a word-aligned read on the data bus. It then performs lane selection and sign/zero extension on the returned word and presents the result (or an AdEL exception) to the writeback side.

## Interface
Parameters:
- DATA_W, 32, bus/register width; legal values 32 or 64
- ADDR_W, 32, address width
- DM_TOP, 32'h2fff, last byte of data RAM (RAM spans 0..DM_TOP)
- TC0_BASE, 32'h7f00, timer 0 base; 12-byte window
- TC1_BASE, 32'h7f10, timer 1 base; 12-byte window
- IRQ_BASE, 32'h7f20, interrupt-ack register base; 4-byte window
- TIMEOUT, 16, bus-wait limit in cycles (used only with LOAD_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (asserted at 0)
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  1=lw, 2=lh, 3=lhu, 4=lb, 5=lbu, 6=lwu and 7=ld (only when DATA_W=64); all other values are illegal
- req_addr  in  ADDR_W  effective byte address
- req_ov  in  1  address-calculation overflow
- bus_req  out  1  read strobe
- bus_addr  out  ADDR_W  word-aligned address; low log2(DATA_W/8) bits are 0
- bus_ack  in  1  read data valid this cycle
- bus_rdata  in  DATA_W  read data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  extended load data; 0 when rsp_exc=1
- rsp_exc  out  1  AdEL
- rsp_tmo  out  1  exception caused by bus timeout

## Operation
- States: IDLE, BUS, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op and addr, then evaluate exceptions.
  - Exception: go to RSP with rsp_exc=1; no bus access.
  - No exception: go to BUS.
- Exception sources (any one raises AdEL):
  - req_ov=1
  - illegal op
  - lw/lwu with addr[1:0]≠0; lh/lhu with addr[0]≠0; ld with addr[2:0]≠0
  - sub-word op (lh/lhu/lb/lbu) hitting either timer window
  - address outside RAM, TC0, TC1 and IRQ windows
- BUS:
  - bus_req=1, and bus_addr holds steady until bus_ack.
  - On bus_ack, select the lane using addr[log2(DATA_W/8)-1:0] and extend: h/hu sign/zero-extend to DATA_W; b/bu likewise; lw sign-extends to DATA_W when DATA_W=64; ld passes through.
  - Result is registered into rsp_data, then go to RSP.
- RSP:
  - rsp_valid=1 and all rsp_* outputs are stable.
  - On rsp_ready, go to IDLE.
- bus_ack outside BUS is ignored.
- Illegal op never reaches the bus.

## Timing
- Reset values: req_ready=0 while reset is asserted and 1 after release. bus_req=0, bus_addr=0, rsp_valid=0, rsp_data=0, rsp_exc=0, rsp_tmo=0; state=IDLE.
- Request acceptance at edge k → bus_req=1 from cycle k+1.
- bus_ack at edge k+n → rsp_valid=1 from cycle k+n+1. Minimum hit latency is 2 cycles.
- Exception accepted at edge k → rsp_valid=1 from cycle k+1.
- RSP with rsp_ready at edge m → IDLE and req_ready=1 from cycle m+1. There are no back-to-back accepts, so throughput is at most one load per 3 cycles.
- Reset asserted in any state: next edge forces IDLE and clears all outputs. The in-flight bus read is abandoned, and a late ack is ignored.

## Configuration
- LOAD_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to BUS and increments each BUS cycle without bus_ack.
  - When it reaches TIMEOUT, go to RSP with rsp_exc=1, rsp_tmo=1, rsp_data=0 and bus_req dropped.
  - bus_ack on the same edge as the limit wins (normal response).
- LOAD_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; rsp_tmo is tied 0.

## Structure
- Package load_pkg holds:
  - op-code localparams (LD_LW..LD_LD)
  - state enum
  - memory-map default constants
- One sub-module, load_ext: combinational lane select and sign/zero extension. Inputs are op, byte offset and word; output is DATA_W. Instantiated once in BUS-capture datapath.

## Test plan
- lb at addr 0x0000_0013, bus_rdata=0x80FF_7F01 (DATA_W=32), ack immediately → rsp_data=0xFFFF_FF80, rsp_exc=0, rsp_valid 2 cycles after accept.
- lhu at 0x0000_0002, rdata=0x9ABC_1234, ack after 3 wait cycles → rsp_data=0x0000_9ABC; bus_addr=0x0000_0000 held steady throughout.
- lw at 0x0000_0006 → rsp_exc=1 one cycle after accept; bus_req never asserted. lh at 0x7f04 → rsp_exc=1. lw at 0x7f04 → bus read issued.
- rsp_ready held 0 for 5 cycles → rsp_valid and rsp_data stable, req_ready=0; release → req_ready=1 next cycle.
- With LOAD_TIMEOUT_EN and TIMEOUT=16, no bus_ack → rsp_exc=1 and rsp_tmo=1 on cycle 18 after accept; a late ack is ignored. Reset asserted in BUS → bus_req=0 and IDLE next cycle.
- DATA_W=64: ld at 0x8, rdata=0x0123_4567_89AB_CDEF → passthrough. lw at 0xC with upper half 0x8000_0000 → rsp_data=0xFFFF_FFFF_8000_0000.
